// File: rtl/pc_stack_unit.sv
// Program counter with an integrated return-address stack for the instruction ROM.
// All state moves on the falling clock edge so pc is settled for the rising-edge ROM read.
module pc_stack_unit #(
    parameter int              AW        = 16,
    parameter int              OW        = 8,
    parameter int              DEPTH     = 8,
    parameter logic [AW-1:0]   RESET_VEC = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     stall,
    input  logic [2:0]               op,
    input  logic [AW-1:0]            target,
    input  logic [OW-1:0]            offset,
    input  logic                     clr_err,
    output logic [AW-1:0]            pc,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     full,
    output logic                     empty,
    output logic                     err_ovf,
    output logic                     err_unf
);

    localparam int PW = $clog2(DEPTH);
    localparam int DW = PW + 1;
    localparam logic [DW-1:0] FULL_CNT = DW'(DEPTH);
    localparam logic [DW-1:0] ONE_CNT  = {{PW{1'b0}}, 1'b1};

    localparam logic [2:0] OP_NEXT   = 3'd1;
    localparam logic [2:0] OP_JUMP   = 3'd2;
    localparam logic [2:0] OP_BRANCH = 3'd3;
    localparam logic [2:0] OP_CALL   = 3'd4;
    localparam logic [2:0] OP_RET    = 3'd5;

    logic [AW-1:0] r_stack [DEPTH];

    logic [AW-1:0] w_pc_inc;
    logic [AW-1:0] w_off_ext;
    logic [AW-1:0] w_top;
    logic [AW-1:0] w_pc_nxt;
    logic [DW-1:0] w_depth_dec;
    logic [DW-1:0] w_depth_nxt;
    logic [PW-1:0] w_pop_idx;
    logic          w_is_full;
    logic          w_is_empty;
    logic          w_push;
    logic          w_ovf_nxt;
    logic          w_unf_nxt;

    assign w_pc_inc    = pc + {{(AW-1){1'b0}}, 1'b1};
    assign w_off_ext   = AW'($signed(offset));
    assign w_depth_dec = depth - ONE_CNT;
    assign w_pop_idx   = w_depth_dec[PW-1:0];
    assign w_top       = r_stack[w_pop_idx];
    assign w_is_full   = (depth == FULL_CNT);
    assign w_is_empty  = (depth == {DW{1'b0}});

    // Next-state decode; a clear is applied first so a faulting op in the same edge still sets its flag.
    always_comb begin
        w_pc_nxt    = pc;
        w_depth_nxt = depth;
        w_ovf_nxt   = err_ovf;
        w_unf_nxt   = err_unf;
        w_push      = 1'b0;
        if (!stall) begin
            if (clr_err) begin
                w_ovf_nxt = 1'b0;
                w_unf_nxt = 1'b0;
            end else begin
                w_ovf_nxt = err_ovf;
                w_unf_nxt = err_unf;
            end
            case (op)
                OP_NEXT:   w_pc_nxt = w_pc_inc;
                OP_JUMP:   w_pc_nxt = target;
                OP_BRANCH: w_pc_nxt = pc + w_off_ext;
                OP_CALL: begin
                    if (w_is_full) begin
                        w_ovf_nxt = 1'b1;
                    end else begin
                        w_push      = 1'b1;
                        w_depth_nxt = depth + ONE_CNT;
                        w_pc_nxt    = target;
                    end
                end
                OP_RET: begin
                    if (w_is_empty) begin
                        w_unf_nxt = 1'b1;
                    end else begin
                        w_pc_nxt    = w_top;
                        w_depth_nxt = w_depth_dec;
                    end
                end
                default:   w_pc_nxt = pc;
            endcase
        end else begin
            w_push = 1'b0;
        end
    end

    // Architectural state and registered status flags.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc      <= RESET_VEC;
            depth   <= {DW{1'b0}};
            full    <= 1'b0;
            empty   <= 1'b1;
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
        end else begin
            pc      <= w_pc_nxt;
            depth   <= w_depth_nxt;
            full    <= (w_depth_nxt == FULL_CNT);
            empty   <= (w_depth_nxt == {DW{1'b0}});
            err_ovf <= w_ovf_nxt;
            err_unf <= w_unf_nxt;
        end
    end

    // Return-address storage; contents are never reset, depth alone defines validity.
    always_ff @(negedge clk) begin
        if (w_push && rst_n) begin
            r_stack[depth[PW-1:0]] <= w_pc_inc;
        end
    end

endmodule

// File: tb/tb_pc_stack_unit.sv
// Self-checking bench for pc_stack_unit: directed vector table, corner sequences,
// and randomized ops compared against a queue-based reference model.
module tb_pc_stack_unit;

    localparam int AW    = 16;
    localparam int OW    = 8;
    localparam int DEPTH = 8;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic          stall = 1'b0;
    logic [2:0]    op    = 3'd0;
    logic [AW-1:0] target = 16'h0000;
    logic [OW-1:0] offset = 8'h00;
    logic          clr_err = 1'b0;
    logic [AW-1:0] pc;
    logic [3:0]    depth;
    logic          full, empty, err_ovf, err_unf;

    int n_checks = 0;
    int n_fail   = 0;

    int unsigned m_pc;
    int unsigned m_stack[$];
    bit          m_ovf, m_unf;

    typedef struct {
        bit          s;
        logic [2:0]  op;
        logic [15:0] tgt;
        logic [7:0]  off;
        bit          clr;
        logic [15:0] e_pc;
        int          e_depth;
    } vec_t;
    vec_t tv [16];

    pc_stack_unit #(.AW(AW), .OW(OW), .DEPTH(DEPTH), .RESET_VEC(16'h0000)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .op(op), .target(target),
        .offset(offset), .clr_err(clr_err), .pc(pc), .depth(depth), .full(full),
        .empty(empty), .err_ovf(err_ovf), .err_unf(err_unf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".pc"},    32'(pc),      m_pc);
        chk({tag, ".depth"}, 32'(depth),   32'(m_stack.size()));
        chk({tag, ".full"},  32'(full),    32'(m_stack.size() == DEPTH));
        chk({tag, ".empty"}, 32'(empty),   32'(m_stack.size() == 0));
        chk({tag, ".ovf"},   32'(err_ovf), 32'(m_ovf));
        chk({tag, ".unf"},   32'(err_unf), 32'(m_unf));
    endtask

    task automatic model_step(input bit s, input logic [2:0] o, input logic [15:0] t,
                              input logic [7:0] off, input bit c);
        int so;
        if (s) return;
        if (c) begin
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end
        case (o)
            3'd1: m_pc = (m_pc + 1) % 65536;
            3'd2: m_pc = t;
            3'd3: begin
                so   = int'($signed(off));
                m_pc = unsigned'((int'(m_pc) + so + 65536) % 65536);
            end
            3'd4: begin
                if (m_stack.size() == DEPTH) m_ovf = 1'b1;
                else begin
                    m_stack.push_back((m_pc + 1) % 65536);
                    m_pc = t;
                end
            end
            3'd5: begin
                if (m_stack.size() == 0) m_unf = 1'b1;
                else m_pc = m_stack.pop_back();
            end
            default: ;
        endcase
    endtask

    task automatic do_edge(input bit s, input logic [2:0] o, input logic [15:0] t,
                           input logic [7:0] off, input bit c, input string tag);
        stall = s; op = o; target = t; offset = off; clr_err = c;
        @(negedge clk);
        model_step(s, o, t, off, c);
        @(posedge clk);
        check_all(tag);
    endtask

    // Called just after a rising edge: reset is pulsed well clear of the next falling edge.
    task automatic do_reset(input string tag);
        #1 rst_n = 1'b0;
        stall = 1'b0; op = 3'd0; clr_err = 1'b0;
        m_pc = 0; m_stack.delete(); m_ovf = 1'b0; m_unf = 1'b0;
        #1 check_all(tag);
        #1 rst_n = 1'b1;
    endtask

    initial begin
        tv[0]  = '{1'b0, 3'd1, 16'h0000, 8'h00, 1'b0, 16'h0001, 0};
        tv[1]  = '{1'b0, 3'd1, 16'h0000, 8'h00, 1'b0, 16'h0002, 0};
        tv[2]  = '{1'b0, 3'd1, 16'h0000, 8'h00, 1'b0, 16'h0003, 0};
        tv[3]  = '{1'b0, 3'd2, 16'hFFFF, 8'h00, 1'b0, 16'hFFFF, 0};
        tv[4]  = '{1'b0, 3'd1, 16'h0000, 8'h00, 1'b0, 16'h0000, 0};
        tv[5]  = '{1'b0, 3'd2, 16'h0002, 8'h00, 1'b0, 16'h0002, 0};
        tv[6]  = '{1'b0, 3'd3, 16'h0000, 8'hFD, 1'b0, 16'hFFFF, 0};
        tv[7]  = '{1'b0, 3'd2, 16'h0010, 8'h00, 1'b0, 16'h0010, 0};
        tv[8]  = '{1'b0, 3'd3, 16'h0000, 8'h7F, 1'b0, 16'h008F, 0};
        tv[9]  = '{1'b0, 3'd2, 16'h0010, 8'h00, 1'b0, 16'h0010, 0};
        tv[10] = '{1'b0, 3'd4, 16'h0100, 8'h00, 1'b0, 16'h0100, 1};
        tv[11] = '{1'b0, 3'd4, 16'h0200, 8'h00, 1'b0, 16'h0200, 2};
        tv[12] = '{1'b0, 3'd5, 16'h0000, 8'h00, 1'b0, 16'h0101, 1};
        tv[13] = '{1'b0, 3'd5, 16'h0000, 8'h00, 1'b0, 16'h0011, 0};
        tv[14] = '{1'b0, 3'd3, 16'h0000, 8'h80, 1'b0, 16'hFF91, 0};
        tv[15] = '{1'b0, 3'd6, 16'h1234, 8'h00, 1'b0, 16'hFF91, 0};

        m_pc = 0; m_ovf = 1'b0; m_unf = 1'b0;
        #1 rst_n = 1'b0;
        @(posedge clk);
        check_all("reset");
        #1 rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            do_edge(tv[i].s, tv[i].op, tv[i].tgt, tv[i].off, tv[i].clr, $sformatf("vec%0d", i));
            chk($sformatf("vec%0d.tbl_pc", i), 32'(pc), 32'(tv[i].e_pc));
            chk($sformatf("vec%0d.tbl_depth", i), 32'(depth), 32'(tv[i].e_depth));
        end
        do_reset("async_rst");
        chk("async_rst.pc_const", 32'(pc), 32'h0000);

        // Overflow, sticky flag and clear, then unwind the full stack.
        for (int i = 0; i < DEPTH; i++) do_edge(1'b0, 3'd4, 16'(16'h0100 + i), 8'h00, 1'b0, "ovf_fill");
        chk("ovf.full", 32'(full), 32'd1);
        do_edge(1'b0, 3'd4, 16'h0ABC, 8'h00, 1'b0, "ovf_call9");
        chk("ovf.pc_held", 32'(pc), 32'h0107);
        chk("ovf.depth", 32'(depth), 32'd8);
        chk("ovf.flag", 32'(err_ovf), 32'd1);
        for (int i = 0; i < 4; i++) begin
            do_edge(1'b0, 3'd1, 16'h0000, 8'h00, 1'b0, "ovf_next");
            chk("ovf.sticky", 32'(err_ovf), 32'd1);
        end
        do_edge(1'b0, 3'd0, 16'h0000, 8'h00, 1'b1, "ovf_clr");
        chk("ovf.cleared", 32'(err_ovf), 32'd0);
        for (int i = 0; i < DEPTH; i++) do_edge(1'b0, 3'd5, 16'h0000, 8'h00, 1'b0, "ovf_unwind");
        chk("ovf.unwound_pc", 32'(pc), 32'h0001);

        // Underflow with clear in the same edge as a second faulting RET.
        do_reset("unf_rst");
        do_edge(1'b0, 3'd5, 16'h0000, 8'h00, 1'b0, "unf_ret");
        chk("unf.flag", 32'(err_unf), 32'd1);
        do_edge(1'b0, 3'd5, 16'h0000, 8'h00, 1'b1, "unf_ret_clr");
        chk("unf.set_wins", 32'(err_unf), 32'd1);

        // Stall freezes everything including clr_err.
        do_edge(1'b0, 3'd4, 16'h0040, 8'h00, 1'b0, "stall_setup");
        do_edge(1'b1, 3'd5, 16'h0000, 8'h00, 1'b0, "stall_ret");
        do_edge(1'b1, 3'd4, 16'h0099, 8'h00, 1'b0, "stall_call");
        do_edge(1'b1, 3'd1, 16'h0000, 8'h00, 1'b0, "stall_next");
        do_edge(1'b1, 3'd0, 16'h0000, 8'h00, 1'b1, "stall_clr");
        chk("stall.pc", 32'(pc), 32'h0040);
        chk("stall.depth", 32'(depth), 32'd1);
        chk("stall.unf", 32'(err_unf), 32'd1);
        do_edge(1'b0, 3'd1, 16'h0000, 8'h00, 1'b0, "stall_release");
        chk("stall.resume", 32'(pc), 32'h0041);

        // Randomized traffic against the reference model.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset("rand_rst");
            do_edge($urandom_range(0, 7) == 0, 3'($urandom_range(0, 7)), 16'($urandom),
                    8'($urandom), $urandom_range(0, 9) == 0, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
